// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared FSM state encoding and digit width for the BCD converter.
package bin2bcd_seq_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_OP   = 2'b01,
      S_DONE = 2'b10
   } state_t;
   localparam int BCD_DIGIT_W = 4;
endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: add-3 correction applied to one BCD digit before each shift.
module bcd_digit_adj
   import bin2bcd_seq_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adj
);
   assign adj = (digit > 4'd4) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, W shift cycles
// per conversion with a start/ready/done_tick handshake.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int W      = 20,
   parameter int DIGITS = 7
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [W-1:0]                  bin,
   output logic                          ready,
   output logic                          done_tick,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);
   localparam int NW = $clog2(W + 1);
   localparam int BW = BCD_DIGIT_W * DIGITS;
   state_t        state;
   logic [NW-1:0] n;
   logic [W-1:0]  p2s;
   logic [BW-1:0] adj;
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit(bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .adj  (adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end
   assign ready     = (state == S_IDLE);
   assign done_tick = (state == S_DONE);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= S_IDLE;
         n     <= '0;
         p2s   <= '0;
         bcd   <= '0;
      end else begin
         case (state)
            S_IDLE:
               if (start) begin
                  p2s   <= bin;
                  bcd   <= '0;
                  n     <= NW'(W);
                  state <= S_OP;
               end
            S_OP: begin
               // adjusted digits shift left with the operand MSB entering digit 0
               bcd   <= {adj[BW-2:0], p2s[W-1]};
               p2s   <= {p2s[W-2:0], 1'b0};
               n     <= n - NW'(1);
               state <= (n == NW'(1)) ? S_DONE : S_OP;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench; a cycle-level acceptance model pushes expected
// BCD results (computed by decimal division) and a negedge monitor checks them.
module tb_bin2bcd_seq;
   localparam int W      = 20;
   localparam int DIGITS = 7;
   localparam int BW     = 4 * DIGITS;

   typedef struct {
      logic [BW-1:0] val;
      int            due;
   } exp_t;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  bin   = '0;
   logic          ready;
   logic          done_tick;
   logic [BW-1:0] bcd;

   int            checks   = 0;
   int            fails    = 0;
   int            cyc      = 0;
   int            free_at  = 0;
   logic [BW-1:0] last_bcd = '0;
   exp_t          sb[$];
   int            done_cycles[$];

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bin      (bin),
      .ready    (ready),
      .done_tick(done_tick),
      .bcd      (bcd)
   );

   function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
      logic [BW-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Acceptance model: a start is taken whenever the previous conversion has fully retired.
   always @(posedge clk) begin
      if (reset && start && cyc >= free_at) begin
         sb.push_back('{val: ref_bcd(32'(bin)), due: cyc + W + 1});
         free_at = cyc + W + 2;
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit exp_done;
      bit idle;
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      idle     = (cyc >= free_at);
      check("ready", 32'(ready), 32'(idle));
      check("done_tick", 32'(done_tick), 32'(exp_done));
      if (exp_done) begin
         check("bcd_result", 32'(bcd), 32'(sb[0].val));
         last_bcd = sb[0].val;
         done_cycles.push_back(cyc);
         void'(sb.pop_front());
      end else if (idle)
         check("bcd_idle", 32'(bcd), 32'(last_bcd));
   end

   task automatic drain();
      for (int i = 0; i < 100 && (sb.size() != 0 || cyc < free_at); i++) @(posedge clk);
      #1;
      check("drain_timeout", 32'(sb.size() != 0 || cyc < free_at), 32'd0);
   endtask

   task automatic convert(input logic [W-1:0] v);
      @(posedge clk); #1;
      bin   = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bin   = W'($urandom);
      drain();
   endtask

   initial begin
      int n0;
      #1 reset = 1'b0;
      #15 reset = 1'b1;
      repeat (3) @(posedge clk);
      convert(0);
      convert(6765);
      convert(1048575);
      convert(9);
      convert(10);
      // re-pulse with a different operand while busy must be ignored
      n0 = done_cycles.size();
      @(posedge clk); #1;
      bin = 6765; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 bin = 500; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drain();
      check("repulse_done_count", 32'(done_cycles.size() - n0), 32'd1);
      // start held high: back-to-back conversions
      n0 = done_cycles.size();
      @(posedge clk); #1;
      bin = 123; start = 1'b1;
      @(posedge clk); #1;
      bin = 4181;
      repeat (22) @(posedge clk);
      #1 start = 1'b0;
      drain();
      check("held_done_count", 32'(done_cycles.size() - n0), 32'd2);
      if (done_cycles.size() - n0 == 2)
         check("held_spacing", 32'(done_cycles[n0+1] - done_cycles[n0]), 32'd22);
      // reset in the middle of a conversion
      n0 = done_cycles.size();
      @(posedge clk); #1;
      bin = 6765; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      free_at  = 0;
      last_bcd = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (25) @(posedge clk);
      #1 check("abort_no_done", 32'(done_cycles.size() - n0), 32'd0);
      convert(89);
      // random traffic, including starts while busy
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 3) == 0);
         bin   = ($urandom_range(0, 9) == 0) ? W'(1048575) : W'($urandom_range(0, (1 << W) - 1));
      end
      start = 1'b0;
      drain();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
